fpga_reset_ctrl: RTL and testbench
==================================

FPGA_RESET_CTRL -- requirements
Module: fpga_reset_ctrl

Interface
REQ-001 The block SHALL have parameter LOCK_FILTER, default 16, giving the consecutive cycles both PLLs must report lock before reset sequencing starts (range 1..255).
REQ-002 The block SHALL have parameter POR_CYCLES, default 8, giving the cycles poresetn is held low in the PORST state (range 1..255).
REQ-003 The block SHALL have parameter HRST_CYCLES, default 4, giving the cycles hresetn is held low after poresetn release (range 1..255).
REQ-004 The block SHALL have port fclk, input, 1 bit: the single clock, the free-running system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port pll_locked, input, 2 bits: lock status of the system PLL [0] and the audio PLL [1], already synchronous to fclk.
REQ-007 The block SHALL have port sysresetreq, input, 1 bit: processor system-reset request, level-sampled each cycle.
REQ-008 The block SHALL have port lock_lost_clr, input, 1 bit: clears the lock_lost flag.
REQ-009 The block SHALL have port poresetn, output, 1 bit: power-on reset to the core and debug, active-low, registered.
REQ-010 The block SHALL have port hresetn, output, 1 bit: AHB system reset, active-low, registered.
REQ-011 The block SHALL have port lock_lost, output, 1 bit: sticky flag set when lock drops after sequencing has begun.
REQ-012 The block SHALL have port state, output, 2 bits: current FSM state, encoded WAIT_LOCK=0, PORST=1, HRST=2, RUN=3.

Function
REQ-013 The FSM SHALL define locked as both pll_locked bits being 1, and an 8-bit counter cnt SHALL time every state.
REQ-014 In WAIT_LOCK the block SHALL increment cnt while locked and clear cnt to 0 in any cycle locked is 0.
REQ-015 In WAIT_LOCK, on a locked cycle with cnt==LOCK_FILTER-1, the FSM SHALL move to PORST with cnt=0.
REQ-016 In PORST the block SHALL increment cnt, and at cnt==POR_CYCLES-1 it SHALL move to HRST with cnt=0 and poresetn=1.
REQ-017 In HRST the block SHALL increment cnt, and at cnt==HRST_CYCLES-1 it SHALL move to RUN with hresetn=1.
REQ-018 In PORST, HRST or RUN, a cycle with locked=0 SHALL move the FSM to WAIT_LOCK on the next edge with poresetn=0, hresetn=0, cnt=0 and lock_lost=1.
REQ-019 In RUN, sysresetreq=1 with locked=1 SHALL move the FSM to HRST with hresetn=0, cnt=0, and poresetn unchanged at 1.
REQ-020 sysresetreq SHALL be ignored in WAIT_LOCK, PORST and HRST, and a held request SHALL not extend HRST.
REQ-021 Lock loss SHALL take priority over sysresetreq in the same cycle.
REQ-022 poresetn SHALL be 1 only in HRST and RUN, and hresetn SHALL be 1 only in RUN.
REQ-023 Neither output SHALL glitch, since both are flop outputs.
REQ-024 lock_lost SHALL clear when lock_lost_clr=1, and a simultaneous set SHALL win over the clear.
REQ-025 With continuous lock from the first sampled cycle, the block SHALL release poresetn LOCK_FILTER+POR_CYCLES edges after lock is first sampled, and hresetn HRST_CYCLES edges later.

Reset
REQ-026 On a rising fclk edge with reset_n=0, the block SHALL set state=WAIT_LOCK, cnt=0, poresetn=0, hresetn=0 and lock_lost=0, regardless of other inputs.
REQ-027 Reset asserted mid-sequence or in RUN SHALL override all transitions, and after release sequencing SHALL restart from WAIT_LOCK with no retained count.

Verification
REQ-028 Scenario "nominal sequence": defaults, locked held from edge 1 -> state changes 0->1 at edge 16; poresetn rises after edge 24; hresetn rises after edge 28; state=3.
REQ-029 Scenario "lock glitch during filter": pll_locked[1]=0 for one cycle at edge 10 -> cnt restarts; poresetn rises 24 edges after lock returns; lock_lost stays 0.
REQ-030 Scenario "lock loss in RUN": drop pll_locked[0] -> next edge poresetn=0, hresetn=0, state=0, lock_lost=1; restore lock -> full 24/28-cycle sequence repeats.
REQ-031 Scenario "system reset request": pulse sysresetreq for 1 cycle in RUN -> hresetn=0 for 4 cycles, poresetn stays 1, then state=3; a 10-cycle request held from RUN gives back-to-back HRST periods, not a stretched one.
REQ-032 Scenario "simultaneous events": sysresetreq=1 and lock drop in the same RUN cycle -> WAIT_LOCK with both resets low; lock_lost_clr=1 coincident with a lock drop -> lock_lost=1.
REQ-033 Scenario "reset mid-PORST": reset_n=0 for 1 cycle at cnt=5 in PORST -> all outputs are at reset values; the sequence restarts from cnt=0 in WAIT_LOCK.

Source files
------------

// File: rtl/fpga_reset_ctrl.sv
// fpga_reset_ctrl: power-on and system reset sequencer for the core and the AHB fabric.
// It waits for both PLLs to hold lock for a filter period, then releases poresetn and
// finally hresetn. A lock loss at any point after sequencing has begun returns to
// WAIT_LOCK and raises a sticky lock_lost flag. A processor reset request in RUN
// re-runs only the hresetn period.
module fpga_reset_ctrl #(
   parameter int LOCK_FILTER = 16,
   parameter int POR_CYCLES  = 8,
   parameter int HRST_CYCLES = 4
) (
   input  logic       fclk,
   input  logic       reset_n,
   input  logic [1:0] pll_locked,
   input  logic       sysresetreq,
   input  logic       lock_lost_clr,
   output logic       poresetn,
   output logic       hresetn,
   output logic       lock_lost,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      PORST     = 2'd1,
      HRST      = 2'd2,
      RUN       = 2'd3
   } state_t;

   // Terminal count values for each timed state, taken as 8-bit constants.
   localparam logic [7:0] LOCK_LAST = 8'(LOCK_FILTER - 1);
   localparam logic [7:0] POR_LAST  = 8'(POR_CYCLES - 1);
   localparam logic [7:0] HRST_LAST = 8'(HRST_CYCLES - 1);

   state_t     cur_state;
   state_t     next_state;
   logic [7:0] cnt;
   logic [7:0] cnt_next;
   logic       poresetn_next;
   logic       hresetn_next;
   logic       lock_lost_next;
   logic       locked;

   assign locked = &pll_locked;
   assign state  = cur_state;

   // Register the state, the shared timer and the three outputs so none can glitch.
   always_ff @(posedge fclk) begin
      if (!reset_n) begin
         cur_state <= WAIT_LOCK;
         cnt       <= 8'd0;
         poresetn  <= 1'b0;
         hresetn   <= 1'b0;
         lock_lost <= 1'b0;
      end else begin
         cur_state <= next_state;
         cnt       <= cnt_next;
         poresetn  <= poresetn_next;
         hresetn   <= hresetn_next;
         lock_lost <= lock_lost_next;
      end
   end

   // Next-state, timer and output decode; lock loss beats any reset request.
   always_comb begin
      next_state     = cur_state;
      cnt_next       = cnt;
      lock_lost_next = lock_lost;

      case (cur_state)
         WAIT_LOCK: begin
            if (!locked) begin
               cnt_next = 8'd0;
            end else if (cnt == LOCK_LAST) begin
               next_state = PORST;
               cnt_next   = 8'd0;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         PORST: begin
            if (!locked) begin
               next_state = WAIT_LOCK;
               cnt_next   = 8'd0;
            end else if (cnt == POR_LAST) begin
               next_state = HRST;
               cnt_next   = 8'd0;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         HRST: begin
            if (!locked) begin
               next_state = WAIT_LOCK;
               cnt_next   = 8'd0;
            end else if (cnt == HRST_LAST) begin
               next_state = RUN;
               cnt_next   = 8'd0;
            end else begin
               cnt_next = cnt + 8'd1;
            end
         end
         RUN: begin
            cnt_next = 8'd0;
            if (!locked) begin
               next_state = WAIT_LOCK;
            end else if (sysresetreq) begin
               next_state = HRST;
            end
         end
         default: begin
            next_state = WAIT_LOCK;
            cnt_next   = 8'd0;
         end
      endcase

      if ((cur_state != WAIT_LOCK) && !locked) begin
         lock_lost_next = 1'b1;
      end else if (lock_lost_clr) begin
         lock_lost_next = 1'b0;
      end

      poresetn_next = (next_state == HRST) || (next_state == RUN);
      hresetn_next  = (next_state == RUN);
   end

endmodule

// File: tb/tb_fpga_reset_ctrl.sv
// tb_fpga_reset_ctrl: scenario tasks plus a randomized run, checked against a
// timeline model that tracks elapsed edges since the sequence or a reset request began.
module tb_fpga_reset_ctrl;

   localparam int LF = 16;
   localparam int PC = 8;
   localparam int HC = 4;

   logic       fclk;
   logic       reset_n;
   logic [1:0] pll_locked;
   logic       sysresetreq;
   logic       lock_lost_clr;
   logic       poresetn;
   logic       hresetn;
   logic       lock_lost;
   logic [1:0] state;

   int checks = 0;
   int errors = 0;

   // Reference model: streak of locked cycles while waiting, edges since sequence
   // start (-1 while waiting), edges since the last reset request (-1 if none).
   int streak = 0;
   int seq_t  = -1;
   int hr_t   = -1;
   bit m_ll   = 1'b0;
   bit m_lk;
   bit m_set;

   fpga_reset_ctrl #(
      .LOCK_FILTER(LF),
      .POR_CYCLES (PC),
      .HRST_CYCLES(HC)
   ) dut (
      .fclk         (fclk),
      .reset_n      (reset_n),
      .pll_locked   (pll_locked),
      .sysresetreq  (sysresetreq),
      .lock_lost_clr(lock_lost_clr),
      .poresetn     (poresetn),
      .hresetn      (hresetn),
      .lock_lost    (lock_lost),
      .state        (state)
   );

   initial fclk = 1'b0;
   always #5 fclk = ~fclk;

   function automatic int m_state();
      if (seq_t < 0) return 0;
      if (hr_t >= 0) return (hr_t < HC) ? 3'd2 : 3'd3;
      if (seq_t < PC) return 1;
      if (seq_t < PC + HC) return 2;
      return 3;
   endfunction

   function automatic logic [4:0] exp_vec();
      int s;
      logic [1:0] s2;
      s  = m_state();
      s2 = 2'(s);
      return {s2, (s >= 2), (s == 3), m_ll};
   endfunction

   function automatic logic [4:0] dut_vec();
      return {state, poresetn, hresetn, lock_lost};
   endfunction

   // Advance the model on every rising edge using the same sampled inputs as the DUT.
   always @(posedge fclk) begin
      m_lk = (pll_locked == 2'b11);
      if (!reset_n) begin
         streak = 0;
         seq_t  = -1;
         hr_t   = -1;
         m_ll   = 1'b0;
      end else begin
         m_set = (seq_t >= 0) && !m_lk;
         if (seq_t < 0) begin
            if (m_lk) begin
               streak++;
               if (streak == LF) begin
                  seq_t  = 0;
                  streak = 0;
               end
            end else begin
               streak = 0;
            end
         end else if (!m_lk) begin
            seq_t  = -1;
            hr_t   = -1;
            streak = 0;
         end else if (m_state() == 3 && sysresetreq) begin
            hr_t = 0;
         end else begin
            seq_t++;
            if (hr_t >= 0) hr_t++;
         end
         m_ll = m_set ? 1'b1 : (lock_lost_clr ? 1'b0 : m_ll);
      end
   end

   task automatic cycle();
      @(posedge fclk);
      @(negedge fclk);
   endtask

   task automatic applyStimulus(input logic rn, input logic [1:0] pl, input logic rq, input logic cl);
      reset_n       = rn;
      pll_locked    = pl;
      sysresetreq   = rq;
      lock_lost_clr = cl;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         cycle();
         checks++;
         if (dut_vec() !== 5'b00000) begin
            errors++;
            $display("[TB] FAIL reset_values got %b exp %b", dut_vec(), 5'b00000);
         end
      end
   endtask

   task automatic test_nominal();
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      cycle();
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
      for (int i = 1; i <= 28; i++) begin
         cycle();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL nominal_model edge %0d got %b exp %b", i, dut_vec(), exp_vec());
         end
         if (i == 15 || i == 16) begin
            checks++;
            if (state !== ((i == 16) ? 2'd1 : 2'd0)) begin
               errors++;
               $display("[TB] FAIL nominal_porst_entry edge %0d got %0d exp %0d", i, state, (i == 16) ? 1 : 0);
            end
         end
         if (i == 23 || i == 24) begin
            checks++;
            if (poresetn !== (i == 24)) begin
               errors++;
               $display("[TB] FAIL nominal_poresetn edge %0d got %b exp %b", i, poresetn, (i == 24));
            end
         end
         if (i == 27 || i == 28) begin
            checks++;
            if (hresetn !== (i == 28)) begin
               errors++;
               $display("[TB] FAIL nominal_hresetn edge %0d got %b exp %b", i, hresetn, (i == 28));
            end
         end
      end
      checks++;
      if (state !== 2'd3) begin
         errors++;
         $display("[TB] FAIL nominal_run got %0d exp 3", state);
      end
   endtask

   task automatic test_lock_loss();
      applyStimulus(1'b1, 2'b10, 1'b0, 1'b0);
      cycle();
      checks++;
      if (dut_vec() !== 5'b00001) begin
         errors++;
         $display("[TB] FAIL lock_loss_run got %b exp %b", dut_vec(), 5'b00001);
      end
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
      for (int i = 1; i <= 28; i++) begin
         cycle();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL lock_loss_model edge %0d got %b exp %b", i, dut_vec(), exp_vec());
         end
         if (i == 23 || i == 24) begin
            checks++;
            if (poresetn !== (i == 24)) begin
               errors++;
               $display("[TB] FAIL lock_loss_poresetn edge %0d got %b exp %b", i, poresetn, (i == 24));
            end
         end
         if (i == 28) begin
            checks++;
            if ({state, hresetn, lock_lost} !== 4'b1111) begin
               errors++;
               $display("[TB] FAIL lock_loss_rerun got %b exp %b", {state, hresetn, lock_lost}, 4'b1111);
            end
         end
      end
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b1);
      cycle();
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
      checks++;
      if (lock_lost !== 1'b0) begin
         errors++;
         $display("[TB] FAIL lock_lost_clear got %b exp 0", lock_lost);
      end
   endtask

   task automatic test_sysreset();
      int highs;
      applyStimulus(1'b1, 2'b11, 1'b1, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         cycle();
         applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL sysreset_model edge %0d got %b exp %b", i, dut_vec(), exp_vec());
         end
         checks++;
         if ({state, poresetn, hresetn} !== ((i < 5) ? 4'b1010 : 4'b1111)) begin
            errors++;
            $display("[TB] FAIL sysreset_pulse edge %0d got %b exp %b", i, {state, poresetn, hresetn},
                     (i < 5) ? 4'b1010 : 4'b1111);
         end
      end
      highs = 0;
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(1'b1, 2'b11, 1'b1, 1'b0);
         cycle();
         if (hresetn === 1'b1) highs++;
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL sysreset_held_model edge %0d got %b exp %b", i, dut_vec(), exp_vec());
         end
      end
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
      checks++;
      if (highs !== 2) begin
         errors++;
         $display("[TB] FAIL sysreset_back_to_back run_samples got %0d exp 2", highs);
      end
   endtask

   task automatic test_simultaneous();
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b1);
      cycle();
      applyStimulus(1'b1, 2'b01, 1'b1, 1'b0);
      cycle();
      checks++;
      if (dut_vec() !== 5'b00001) begin
         errors++;
         $display("[TB] FAIL simultaneous_req_drop got %b exp %b", dut_vec(), 5'b00001);
      end
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b1);
      cycle();
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
      checks++;
      if (lock_lost !== 1'b0) begin
         errors++;
         $display("[TB] FAIL simultaneous_clear got %b exp 0", lock_lost);
      end
      for (int i = 2; i <= 16; i++) cycle();
      checks++;
      if (state !== 2'd1) begin
         errors++;
         $display("[TB] FAIL simultaneous_porst got %0d exp 1", state);
      end
      applyStimulus(1'b1, 2'b01, 1'b0, 1'b1);
      cycle();
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
      checks++;
      if ({state, lock_lost} !== 3'b001) begin
         errors++;
         $display("[TB] FAIL simultaneous_set_wins got %b exp %b", {state, lock_lost}, 3'b001);
      end
   endtask

   task automatic test_lock_glitch();
      applyStimulus(1'b0, 2'b11, 1'b0, 1'b0);
      cycle();
      for (int i = 1; i <= 38; i++) begin
         applyStimulus(1'b1, (i == 10) ? 2'b01 : 2'b11, 1'b0, 1'b0);
         cycle();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL glitch_model edge %0d got %b exp %b", i, dut_vec(), exp_vec());
         end
         if (i == 33 || i == 34) begin
            checks++;
            if ({poresetn, lock_lost} !== {(i == 34), 1'b0}) begin
               errors++;
               $display("[TB] FAIL glitch_poresetn edge %0d got %b exp %b", i, {poresetn, lock_lost}, {(i == 34), 1'b0});
            end
         end
      end
      checks++;
      if ({state, hresetn, lock_lost} !== 4'b1110) begin
         errors++;
         $display("[TB] FAIL glitch_run got %b exp %b", {state, hresetn, lock_lost}, 4'b1110);
      end
   endtask

   task automatic test_reset_mid_porst();
      applyStimulus(1'b0, 2'b11, 1'b0, 1'b0);
      cycle();
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
      for (int i = 1; i <= 21; i++) cycle();
      checks++;
      if (state !== 2'd1) begin
         errors++;
         $display("[TB] FAIL mid_porst_reach got %0d exp 1", state);
      end
      applyStimulus(1'b0, 2'b11, 1'b1, 1'b0);
      cycle();
      checks++;
      if (dut_vec() !== 5'b00000) begin
         errors++;
         $display("[TB] FAIL mid_porst_reset got %b exp %b", dut_vec(), 5'b00000);
      end
      applyStimulus(1'b1, 2'b11, 1'b0, 1'b0);
      for (int i = 1; i <= 16; i++) begin
         cycle();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL mid_porst_model edge %0d got %b exp %b", i, dut_vec(), exp_vec());
         end
         if (i == 15 || i == 16) begin
            checks++;
            if (state !== ((i == 16) ? 2'd1 : 2'd0)) begin
               errors++;
               $display("[TB] FAIL mid_porst_restart edge %0d got %0d exp %0d", i, state, (i == 16) ? 1 : 0);
            end
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(1'($urandom_range(0, 199) != 0),
                       ($urandom_range(0, 39) == 0) ? 2'($urandom_range(0, 2)) : 2'b11,
                       1'($urandom_range(0, 15) == 0),
                       1'($urandom_range(0, 15) == 0));
         cycle();
         checks++;
         if (dut_vec() !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL random_model cycle %0d got %b exp %b", i, dut_vec(), exp_vec());
         end
      end
   endtask

   // Run the scenarios in order; each leaves the DUT where the next one expects it.
   initial begin
      applyStimulus(1'b0, 2'b00, 1'b0, 1'b0);
      test_reset();
      test_nominal();
      test_lock_loss();
      test_sysreset();
      test_simultaneous();
      test_lock_glitch();
      test_reset_mid_porst();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
